multicycle_controller: RTL and testbench

- Multicycle control FSM for the RV32I subset datapath: R-type, LW, SW, BEQ/BNE and ADDI.
- Sequences one shared instruction/data memory port and one ALU across several cycles per instruction.
- Drives datapath mux selects and write enables; the datapath evaluates the branch condition.
- Sits between the IR opcode field and the datapath. Adds halt control, a memory ready-handshake with timeout, a retired-instruction counter and sticky fault flags.

---
 rtl/ctrl_pkg.sv | 40 ++++
 rtl/multicycle_controller_if.sv | 41 ++++
 rtl/mem_wait_timer.sv | 32 +++
 rtl/multicycle_controller.sv | 170 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcodes, FSM states and datapath select encodings for the multicycle controller.
package ctrl_pkg;

  localparam int unsigned OPCODE_W = 7;

  localparam logic [OPCODE_W-1:0] R_TYPE       = 7'b0110011;
  localparam logic [OPCODE_W-1:0] LW           = 7'b0000011;
  localparam logic [OPCODE_W-1:0] SW           = 7'b0100011;
  localparam logic [OPCODE_W-1:0] BR           = 7'b1100011;
  localparam logic [OPCODE_W-1:0] INT_IMED_REG = 7'b0010011;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    MEM_ADDR,
    MEM_RD,
    MEM_WB,
    MEM_WR,
    EXEC_R,
    EXEC_I,
    ALU_WB,
    BRANCH,
    ILLEGAL,
    FAULT
  } state_t;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  localparam logic [1:0] SRC_B_RS2    = 2'b00;
  localparam logic [1:0] SRC_B_IMM    = 2'b01;
  localparam logic [1:0] SRC_B_FOUR   = 2'b10;

  localparam logic [1:0] ALU_ADD      = 2'b00;
  localparam logic [1:0] ALU_BRANCH   = 2'b01;
  localparam logic [1:0] ALU_FUNCT    = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle: IR opcode, handshake and all control strobes.
interface multicycle_controller_if #(
  parameter int unsigned CNT_W = 32
);

  logic [6:0]       opcode;
  logic             halt;
  logic             mem_ready;
  logic             mem_rd;
  logic             mem_wr;
  logic             iord;
  logic             ir_write;
  logic             pc_write;
  logic             pc_src;
  logic             branch;
  logic             reg_write;
  logic             mem_to_reg;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             retire;
  logic [CNT_W-1:0] instr_count;
  logic             busy;
  logic             illegal_op;
  logic             bus_error;

  modport master (
    input  opcode, halt, mem_ready,
    output mem_rd, mem_wr, iord, ir_write, pc_write, pc_src, branch,
           reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           retire, instr_count, busy, illegal_op, bus_error
  );

  modport slave (
    output opcode, halt, mem_ready,
    input  mem_rd, mem_wr, iord, ir_write, pc_write, pc_src, branch,
           reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           retire, instr_count, busy, illegal_op, bus_error
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts unanswered memory request cycles; expired flags that this cycle's wait reaches TIMEOUT.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] count;

  // Wait-cycle counter, restarted whenever no request is pending or one completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (waiting) begin
      count <= count + CW'(1);
    end
  end

  // Not gated by waiting so the FSM can use it without a combinational loop; TIMEOUT=0 never expires.
  always_comb begin
    expired = (TIMEOUT != 0) && (count == CW'(TIMEOUT - 1));
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I-subset control FSM with halt, memory handshake timeout and retire counter.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input logic                    clk,
  input logic                    reset,
  multicycle_controller_if.master bus
);

  state_t           state;
  state_t           next;
  logic [CNT_W-1:0] count_q;
  logic             retire_c;
  logic             timer_clear_c;
  logic             timer_wait_c;
  logic             expired;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear_c),
    .waiting (timer_wait_c),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  // Retired-instruction counter; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (retire_c) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Next state and Mealy control outputs.
  always_comb begin
    next           = state;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.iord       = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 1'b0;
    bus.branch     = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = SRC_A_PC;
    bus.alu_src_b  = SRC_B_RS2;
    bus.alu_op     = ALU_ADD;
    retire_c       = 1'b0;
    timer_clear_c  = 1'b1;
    timer_wait_c   = 1'b0;

    unique case (state)
      IDLE: begin
        if (!bus.halt) next = FETCH;
      end
      FETCH: begin
        bus.mem_rd    = 1'b1;
        bus.iord      = 1'b0;
        bus.alu_src_a = SRC_A_PC;
        bus.alu_src_b = SRC_B_FOUR;
        bus.alu_op    = ALU_ADD;
        timer_clear_c = bus.mem_ready;
        timer_wait_c  = !bus.mem_ready;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          next         = DECODE;
        end else if (expired) begin
          next = FAULT;
        end
      end
      DECODE: begin
        bus.alu_src_a = SRC_A_OLD_PC;
        bus.alu_src_b = SRC_B_IMM;
        bus.alu_op    = ALU_ADD;
        if (bus.opcode == LW || bus.opcode == SW) next = MEM_ADDR;
        else if (bus.opcode == R_TYPE)            next = EXEC_R;
        else if (bus.opcode == INT_IMED_REG)      next = EXEC_I;
        else if (bus.opcode == BR)                next = BRANCH;
        else                                      next = ILLEGAL;
      end
      MEM_ADDR: begin
        bus.alu_src_a = SRC_A_RS1;
        bus.alu_src_b = SRC_B_IMM;
        bus.alu_op    = ALU_ADD;
        next          = (bus.opcode == SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        bus.mem_rd    = 1'b1;
        bus.iord      = 1'b1;
        timer_clear_c = bus.mem_ready;
        timer_wait_c  = !bus.mem_ready;
        if (bus.mem_ready) next = MEM_WB;
        else if (expired)  next = FAULT;
      end
      MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        retire_c       = 1'b1;
        next           = bus.halt ? IDLE : FETCH;
      end
      MEM_WR: begin
        bus.mem_wr    = 1'b1;
        bus.iord      = 1'b1;
        timer_clear_c = bus.mem_ready;
        timer_wait_c  = !bus.mem_ready;
        if (bus.mem_ready) begin
          retire_c = 1'b1;
          next     = bus.halt ? IDLE : FETCH;
        end else if (expired) begin
          next = FAULT;
        end
      end
      EXEC_R: begin
        bus.alu_src_a = SRC_A_RS1;
        bus.alu_src_b = SRC_B_RS2;
        bus.alu_op    = ALU_FUNCT;
        next          = ALU_WB;
      end
      EXEC_I: begin
        bus.alu_src_a = SRC_A_RS1;
        bus.alu_src_b = SRC_B_IMM;
        bus.alu_op    = ALU_FUNCT;
        next          = ALU_WB;
      end
      ALU_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b0;
        retire_c       = 1'b1;
        next           = bus.halt ? IDLE : FETCH;
      end
      BRANCH: begin
        bus.alu_src_a = SRC_A_RS1;
        bus.alu_src_b = SRC_B_RS2;
        bus.alu_op    = ALU_BRANCH;
        bus.branch    = 1'b1;
        bus.pc_src    = 1'b1;
        retire_c      = 1'b1;
        next          = bus.halt ? IDLE : FETCH;
      end
      ILLEGAL: next = ILLEGAL;
      FAULT:   next = FAULT;
      default: next = IDLE;
    endcase
  end

  // Status outputs; the sticky flags follow the terminal states.
  always_comb begin
    bus.retire      = retire_c;
    bus.instr_count = count_q;
    bus.busy        = !(state == IDLE || state == ILLEGAL || state == FAULT);
    bus.illegal_op  = (state == ILLEGAL);
    bus.bus_error   = (state == FAULT);
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven, scoreboarded bench for multicycle_controller (TIMEOUT=8).
module tb_multicycle_controller;

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned TIMEOUT = 8;

  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  logic clk = 1'b0;
  logic reset;

  multicycle_controller_if #(.CNT_W(CNT_W)) bus ();

  multicycle_controller #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       branch;
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       retire;
    logic       busy;
    logic       illegal_op;
    logic       bus_error;
  } ctl_t;

  // Expected output sets per state/phase, written from the state table.
  localparam ctl_t E_IDLE = '0;
  localparam ctl_t E_FW   = '{mem_rd:1'b1, alu_src_b:2'b10, busy:1'b1, default:'0};
  localparam ctl_t E_FR   = '{mem_rd:1'b1, ir_write:1'b1, pc_write:1'b1, alu_src_b:2'b10, busy:1'b1, default:'0};
  localparam ctl_t E_DEC  = '{alu_src_a:2'b01, alu_src_b:2'b01, busy:1'b1, default:'0};
  localparam ctl_t E_MAD  = '{alu_src_a:2'b10, alu_src_b:2'b01, busy:1'b1, default:'0};
  localparam ctl_t E_MRD  = '{mem_rd:1'b1, iord:1'b1, busy:1'b1, default:'0};
  localparam ctl_t E_MWB  = '{reg_write:1'b1, mem_to_reg:1'b1, retire:1'b1, busy:1'b1, default:'0};
  localparam ctl_t E_MWR  = '{mem_wr:1'b1, iord:1'b1, busy:1'b1, default:'0};
  localparam ctl_t E_MWE  = '{mem_wr:1'b1, iord:1'b1, retire:1'b1, busy:1'b1, default:'0};
  localparam ctl_t E_EXR  = '{alu_src_a:2'b10, alu_op:2'b10, busy:1'b1, default:'0};
  localparam ctl_t E_EXI  = '{alu_src_a:2'b10, alu_src_b:2'b01, alu_op:2'b10, busy:1'b1, default:'0};
  localparam ctl_t E_AWB  = '{reg_write:1'b1, retire:1'b1, busy:1'b1, default:'0};
  localparam ctl_t E_BR   = '{alu_src_a:2'b10, alu_op:2'b01, branch:1'b1, pc_src:1'b1, retire:1'b1, busy:1'b1, default:'0};
  localparam ctl_t E_ILL  = '{illegal_op:1'b1, default:'0};
  localparam ctl_t E_FLT  = '{bus_error:1'b1, default:'0};

  typedef struct {
    logic       rst;
    logic       halt;
    logic       rdy;
    logic [6:0] op;
    ctl_t       exp;
    int         cnt;
  } vec_t;

  typedef struct {
    ctl_t exp;
    int   cnt;
    int   idx;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   row   = 0;

  function automatic ctl_t observe();
    ctl_t c;
    c.mem_rd     = bus.mem_rd;
    c.mem_wr     = bus.mem_wr;
    c.iord       = bus.iord;
    c.ir_write   = bus.ir_write;
    c.pc_write   = bus.pc_write;
    c.pc_src     = bus.pc_src;
    c.branch     = bus.branch;
    c.reg_write  = bus.reg_write;
    c.mem_to_reg = bus.mem_to_reg;
    c.alu_src_a  = bus.alu_src_a;
    c.alu_src_b  = bus.alu_src_b;
    c.alu_op     = bus.alu_op;
    c.retire     = bus.retire;
    c.busy       = bus.busy;
    c.illegal_op = bus.illegal_op;
    c.bus_error  = bus.bus_error;
    return c;
  endfunction

  function automatic void add(logic rst, logic halt, logic rdy, logic [6:0] op, ctl_t exp, int cnt);
    vec_t v;
    v.rst = rst; v.halt = halt; v.rdy = rdy; v.op = op; v.exp = exp; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  task automatic check_ctl(string name, ctl_t act, ctl_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: controls got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_cnt(string name, logic [CNT_W-1:0] act, int exp);
    tests++;
    if (act !== CNT_W'(exp)) begin
      fails++;
      $display("FAIL %s: instr_count got %0d required %0d", name, act, exp);
    end
  endtask

  // Drive one vector after the edge, record its expectation, compare on the falling edge.
  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) begin
      sb_t e;
      @(posedge clk);
      #1;
      reset         = vecs[i].rst;
      bus.halt      = vecs[i].halt;
      bus.mem_ready = vecs[i].rdy;
      bus.opcode    = vecs[i].op;
      e.exp = vecs[i].exp; e.cnt = vecs[i].cnt; e.idx = row;
      sb_q.push_back(e);
      row++;
      @(negedge clk);
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard: queue empty at row %0d", row);
      end else begin
        e = sb_q.pop_front();
        check_ctl($sformatf("row%0d", e.idx), observe(), e.exp);
        check_cnt($sformatf("row%0d_cnt", e.idx), bus.instr_count, e.cnt);
      end
    end
    vecs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.halt      = 1'b1;
    bus.mem_ready = 1'b0;
    bus.opcode    = OP_ADDI;

    // Reset, then ADDI with immediate ready
    add(1, 1, 0, OP_ADDI, E_IDLE, 0);
    add(0, 0, 1, OP_ADDI, E_IDLE, 0);
    add(0, 0, 1, OP_ADDI, E_FR,   0);
    add(0, 0, 1, OP_ADDI, E_DEC,  0);
    add(0, 0, 1, OP_ADDI, E_EXI,  0);
    add(0, 0, 1, OP_ADDI, E_AWB,  0);
    // LW with three unanswered read cycles
    add(0, 0, 1, OP_LW, E_FR,  1);
    add(0, 0, 1, OP_LW, E_DEC, 1);
    add(0, 0, 1, OP_LW, E_MAD, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 0, OP_LW, E_MRD, 1);
    add(0, 0, 1, OP_LW, E_MRD, 1);
    add(0, 0, 1, OP_LW, E_MWB, 1);
    // BEQ then SW (with a fetch wait), halt at SW end
    add(0, 0, 1, OP_BR, E_FR,  2);
    add(0, 0, 1, OP_BR, E_DEC, 2);
    add(0, 0, 1, OP_BR, E_BR,  2);
    add(0, 0, 0, OP_SW, E_FW,  3);
    add(0, 0, 1, OP_SW, E_FR,  3);
    add(0, 0, 1, OP_SW, E_DEC, 3);
    add(0, 0, 1, OP_SW, E_MAD, 3);
    add(0, 0, 0, OP_SW, E_MWR, 3);
    add(0, 0, 0, OP_SW, E_MWR, 3);
    add(0, 1, 1, OP_SW, E_MWE, 3);
    add(0, 1, 0, OP_SW, E_IDLE, 4);
    add(0, 1, 1, OP_SW, E_IDLE, 4);
    // halt raised mid-instruction does not abort it
    add(0, 0, 0, OP_ADDI, E_IDLE, 4);
    add(0, 1, 1, OP_ADDI, E_FR,   4);
    add(0, 1, 1, OP_ADDI, E_DEC,  4);
    add(0, 1, 1, OP_ADDI, E_EXI,  4);
    add(0, 1, 1, OP_ADDI, E_AWB,  4);
    add(0, 1, 1, OP_ADDI, E_IDLE, 5);
    // R-type
    add(0, 0, 0, OP_R, E_IDLE, 5);
    add(0, 0, 1, OP_R, E_FR,   5);
    add(0, 0, 1, OP_R, E_DEC,  5);
    add(0, 0, 1, OP_R, E_EXR,  5);
    add(0, 0, 1, OP_R, E_AWB,  5);
    // Illegal opcode: terminal, ignores halt/mem_ready; reset recovers
    add(0, 0, 1, OP_BAD, E_FR,  6);
    add(0, 0, 1, OP_BAD, E_DEC, 6);
    add(0, 0, 1, OP_BAD, E_ILL, 6);
    for (int i = 0; i < 20; i++) add(0, 1'(i & 1), 1'((i >> 1) & 1), OP_BAD, E_ILL, 6);
    add(1, 1, 0, OP_BAD, E_IDLE, 0);
    add(0, 1, 0, OP_BAD, E_IDLE, 0);
    // Fetch timeout after 8 unanswered cycles
    add(0, 0, 0, OP_ADDI, E_IDLE, 0);
    for (int i = 0; i < 8; i++) add(0, 0, 0, OP_ADDI, E_FW, 0);
    for (int i = 0; i < 6; i++) add(0, 1'(i & 1), 1, OP_ADDI, E_FLT, 0);
    add(1, 0, 0, OP_ADDI, E_IDLE, 0);
    // Ready on wait cycle 8 wins, and the counter restarts for the data read
    add(0, 0, 0, OP_LW, E_IDLE, 0);
    for (int i = 0; i < 7; i++) add(0, 0, 0, OP_LW, E_FW, 0);
    add(0, 0, 1, OP_LW, E_FR,  0);
    add(0, 0, 1, OP_LW, E_DEC, 0);
    add(0, 0, 1, OP_LW, E_MAD, 0);
    for (int i = 0; i < 7; i++) add(0, 0, 0, OP_LW, E_MRD, 0);
    add(0, 0, 1, OP_LW, E_MRD, 0);
    add(0, 1, 1, OP_LW, E_MWB, 0);
    add(0, 1, 0, OP_LW, E_IDLE, 1);
    // Walk into MEM_WR and leave the write pending
    add(0, 0, 0, OP_SW, E_IDLE, 1);
    add(0, 0, 1, OP_SW, E_FR,   1);
    add(0, 0, 1, OP_SW, E_DEC,  1);
    add(0, 0, 1, OP_SW, E_MAD,  1);
    add(0, 0, 0, OP_SW, E_MWR,  1);
    run_vecs();

    // Asynchronous reset mid-write: outputs clear before any clock edge
    #2;
    reset = 1'b1;
    bus.halt = 1'b1;
    #1;
    check_ctl("async_reset", observe(), E_IDLE);
    check_cnt("async_reset_cnt", bus.instr_count, 0);

    // Held in IDLE by halt after release, then fetch once halt drops
    add(1, 1, 0, OP_SW, E_IDLE, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 1, OP_SW, E_IDLE, 0);
    add(0, 0, 0, OP_SW, E_IDLE, 0);
    add(0, 0, 0, OP_SW, E_FW,   0);
    run_vecs();

    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard: %0d entries left unchecked", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
